// File: rtl/lfsr_sched_pkg.sv
// Shared types and constants for the LFSR burst scheduler.
// LFSR_SEED is the value the external LFSR resets and reloads to.
package lfsr_sched_pkg;

  localparam int RAND_W = 12;
  localparam logic [RAND_W-1:0] LFSR_SEED = 12'hAA7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_STREAM,
    ST_RESEED
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// The search starts one past the previous winner and wraps modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  logic found;
  int   idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    // Offset NUM_REQ lands on last_grant itself, so it only wins when alone.
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/lfsr_rand_sched.sv
// Shares one external 12-bit LFSR among NUM_REQ burst requesters.
// Reseed requests are held back until the current burst has finished.
module lfsr_rand_sched
  import lfsr_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*CNT_W-1:0] req_count,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     reseed,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [RAND_W-1:0]        rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_last,
  output logic                     lfsr_gen,
  output logic                     lfsr_load,
  input  logic [RAND_W-1:0]        lfsr_value,
  output logic [15:0]              words_issued
);

  sched_state_t       state;
  sched_state_t       state_next;
  logic               reseed_pend;
  logic [CNT_W-1:0]   remaining;
  logic [ID_W-1:0]    cur_id;
  logic [ID_W-1:0]    last_grant;
  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_id;
  logic [CNT_W-1:0]   grant_count;
  logic               any_req;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arbiter (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_id   (arb_id)
  );

  assign any_req     = |req_valid;
  assign grant_count = req_count[int'(arb_id)*CNT_W +: CNT_W];
  assign accept      = (state == ST_STREAM) && rsp_ready;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (reseed_pend) begin
          state_next = ST_RESEED;
        end else if (any_req) begin
          state_next = ST_ARB;
        end
      end
      ST_ARB: begin
        if (!any_req || grant_count == '0) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (rsp_ready && remaining == CNT_W'(1)) begin
          state_next = ST_IDLE;
        end
      end
      ST_RESEED: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // lfsr_gen follows rsp_ready directly so the LFSR steps on the accepting edge.
  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    rsp_id    = '0;
    rsp_last  = 1'b0;
    lfsr_gen  = 1'b0;
    lfsr_load = 1'b0;
    unique case (state)
      ST_ARB: req_ready = arb_grant;
      ST_STREAM: begin
        rsp_valid = 1'b1;
        rsp_data  = lfsr_value;
        rsp_id    = cur_id;
        rsp_last  = (remaining == CNT_W'(1));
        lfsr_gen  = rsp_ready;
      end
      ST_RESEED: lfsr_load = 1'b1;
      default: ;
    endcase
  end

  // A pulse coinciding with the RESEED cycle wins, so it re-arms the request.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      reseed_pend <= 1'b0;
    end else if (reseed) begin
      reseed_pend <= 1'b1;
    end else if (state == ST_RESEED) begin
      reseed_pend <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      remaining    <= '0;
      cur_id       <= '0;
      last_grant   <= ID_W'(NUM_REQ - 1);
      words_issued <= '0;
    end else begin
      if (state == ST_ARB && any_req) begin
        remaining  <= grant_count;
        cur_id     <= arb_id;
        last_grant <= arb_id;
      end else if (accept) begin
        remaining <= remaining - CNT_W'(1);
      end
      if (accept) begin
        words_issued <= words_issued + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rand_sched.sv
// Scoreboard bench for lfsr_rand_sched with a local 12-bit Galois LFSR as the sibling generator.
// Expected words are queued when a request is driven and checked as the DUT hands them out.
module tb_lfsr_rand_sched;
  import lfsr_sched_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 8;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [RAND_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic              last;
  } exp_word_t;

  logic                     CLK = 1'b0;
  logic                     RST_N;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*CNT_W-1:0] req_count;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     reseed;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [RAND_W-1:0]        rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_last;
  logic                     lfsr_gen;
  logic                     lfsr_load;
  logic [RAND_W-1:0]        lfsr_value;
  logic [15:0]              words_issued;

  exp_word_t         expQ[$];
  exp_word_t         monWord;
  exp_word_t         pushWord;
  logic [RAND_W-1:0] expLfsr;
  int                compared   = 0;
  int                mismatched = 0;
  int                expWords   = 0;
  int                loadCount  = 0;
  int                loadBase;
  int                lastWait;
  int                waitCnt;
  logic              burstOpen  = 1'b0;

  always #5 CLK = ~CLK;

  lfsr_rand_sched #(
    .NUM_REQ(NUM_REQ),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .req_valid   (req_valid),
    .req_count   (req_count),
    .req_ready   (req_ready),
    .reseed      (reseed),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id),
    .rsp_last    (rsp_last),
    .lfsr_gen    (lfsr_gen),
    .lfsr_load   (lfsr_load),
    .lfsr_value  (lfsr_value),
    .words_issued(words_issued)
  );

  function automatic logic [RAND_W-1:0] lfsrNext(input logic [RAND_W-1:0] s);
    lfsrNext = {s[RAND_W-2:0], 1'b0} ^ (s[RAND_W-1] ? 12'hA97 : 12'h000);
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      lfsr_value <= LFSR_SEED;
    end else if (lfsr_load) begin
      lfsr_value <= LFSR_SEED;
    end else if (lfsr_gen) begin
      lfsr_value <= lfsrNext(lfsr_value);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, wanted %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic waitGrant(input int idx, output int cycles);
    cycles = 0;
    do begin
      @(negedge CLK);
      cycles++;
    end while (req_ready == '0 && cycles < 50);
    checkOutput("grant", 32'(req_ready), 32'(1) << idx);
  endtask

  task automatic queueBurst(input int idx, input int count);
    for (int k = 0; k < count; k++) begin
      pushWord.data = expLfsr;
      pushWord.id   = ID_W'(idx);
      pushWord.last = (k == count - 1);
      expQ.push_back(pushWord);
      expLfsr = lfsrNext(expLfsr);
    end
  endtask

  task automatic applyStimulus(input int idx, input int count);
    int cycles;
    @(posedge CLK);
    #1;
    queueBurst(idx, count);
    req_count[idx*CNT_W +: CNT_W] = CNT_W'(count);
    req_valid[idx] = 1'b1;
    waitGrant(idx, cycles);
    @(posedge CLK);
    #1;
    req_valid[idx] = 1'b0;
    lastWait = cycles;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("drain", 32'(expQ.size()), 32'd0);
    repeat (3) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (!RST_N) begin
      burstOpen = 1'b0;
      expWords  = 0;
    end else begin
      if (lfsr_load) begin
        loadCount++;
        checkOutput("load_mid_burst", 32'(burstOpen), 32'd0);
        checkOutput("gen_load_excl", 32'(lfsr_gen), 32'd0);
      end
      if (rsp_valid && rsp_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_word", 32'(rsp_data), 32'hFFFF_FFFF);
        end else begin
          monWord = expQ.pop_front();
          checkOutput("rsp_data", 32'(rsp_data), 32'(monWord.data));
          checkOutput("rsp_id", 32'(rsp_id), 32'(monWord.id));
          checkOutput("rsp_last", 32'(rsp_last), 32'(monWord.last));
          burstOpen = !monWord.last;
          expWords++;
        end
      end
    end
  end

  initial begin
    RST_N     = 1'b0;
    req_valid = '0;
    req_count = '0;
    reseed    = 1'b0;
    rsp_ready = 1'b1;
    expLfsr   = LFSR_SEED;
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
    checkOutput("reset_outputs", 32'({req_ready, rsp_valid, rsp_data, rsp_id, rsp_last, lfsr_gen, lfsr_load}), 32'd0);
    checkOutput("reset_words", 32'(words_issued), 32'd0);

    $display("[TB] single burst after reset");
    applyStimulus(0, 3);
    checkOutput("grant_latency", 32'(lastWait), 32'd2);
    waitDrain();
    checkOutput("words_burst1", 32'(words_issued), 32'd3);

    $display("[TB] backpressure");
    applyStimulus(3, 6);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_data", 32'(rsp_data), 32'(expQ[0].data));
      checkOutput("bp_id", 32'(rsp_id), 32'd3);
      checkOutput("bp_last", 32'(rsp_last), 32'(expQ[0].last));
      checkOutput("bp_gen", 32'(lfsr_gen), 32'd0);
    end
    @(posedge CLK);
    #1;
    rsp_ready = 1'b1;
    waitDrain();
    checkOutput("words_bp", 32'(words_issued), 32'd9);

    $display("[TB] round-robin fairness");
    @(posedge CLK);
    #1;
    for (int k = 0; k < 8; k++) begin
      queueBurst(k % NUM_REQ, 1);
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      req_count[r*CNT_W +: CNT_W] = CNT_W'(1);
    end
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      waitGrant(k % NUM_REQ, waitCnt);
    end
    @(posedge CLK);
    #1;
    req_valid = '0;
    waitDrain();
    checkOutput("words_rr", 32'(words_issued), 32'd17);

    $display("[TB] deferred reseed");
    loadBase = loadCount;
    applyStimulus(1, 5);
    @(posedge CLK);
    #1;
    reseed = 1'b1;
    @(posedge CLK);
    #1;
    reseed = 1'b0;
    waitDrain();
    checkOutput("load_pulses", 32'(loadCount - loadBase), 32'd1);
    expLfsr = LFSR_SEED;
    applyStimulus(2, 2);
    waitDrain();

    $display("[TB] zero-length request");
    applyStimulus(2, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checkOutput("zero_no_valid", 32'(rsp_valid), 32'd0);
      checkOutput("zero_no_ready", 32'(req_ready), 32'd0);
    end
    checkOutput("zero_words", 32'(words_issued), 32'(expWords & 16'hFFFF));

    $display("[TB] reset mid-burst");
    applyStimulus(1, 6);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    expQ.delete();
    expLfsr = LFSR_SEED;
    @(negedge CLK);
    checkOutput("rst_outputs", 32'({req_ready, rsp_valid, rsp_data, rsp_id, rsp_last, lfsr_gen, lfsr_load}), 32'd0);
    checkOutput("rst_words", 32'(words_issued), 32'd0);
    @(posedge CLK);
    #1;
    queueBurst(0, 1);
    queueBurst(2, 1);
    req_count[0*CNT_W +: CNT_W] = CNT_W'(1);
    req_count[2*CNT_W +: CNT_W] = CNT_W'(1);
    req_valid = 4'b0101;
    waitGrant(0, waitCnt);
    @(posedge CLK);
    #1;
    req_valid[0] = 1'b0;
    waitGrant(2, waitCnt);
    @(posedge CLK);
    #1;
    req_valid[2] = 1'b0;
    waitDrain();
    checkOutput("words_after_rst", 32'(words_issued), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, wanted finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
